// File: rtl/clock_module_if.sv
// Control inputs and clock outputs of clock_module, bundled for the module boundary.
// master drives the controls and observes the clock; slave is the clock generator.
interface clock_module_if #(
   parameter int DIV_WIDTH = 16
);
   logic [DIV_WIDTH-1:0] half_period;
   logic                 mode_manual;
   logic                 mode_auto;
   logic                 step_btn;
   logic                 halt;
   logic                 sys_clk;
   logic                 sys_clk_n;
   logic                 clk_rise;
   logic                 clk_fall;
   logic                 is_manual;
   logic                 halted;
   logic [15:0]          cycle_count;

   modport master (
      output half_period, mode_manual, mode_auto, step_btn, halt,
      input  sys_clk, sys_clk_n, clk_rise, clk_fall, is_manual, halted, cycle_count
   );

   modport slave (
      input  half_period, mode_manual, mode_auto, step_btn, halt,
      output sys_clk, sys_clk_n, clk_rise, clk_fall, is_manual, halted, cycle_count
   );
endinterface

// File: rtl/clock_module.sv
// SAP-U system clock generator: astable divider or debounced single-step, with sticky halt.
// Optional rising-edge counter on cycle_count is enabled by CLOCK_MODULE_CYCLE_COUNT_EN.
module clock_module #(
   parameter int DIV_WIDTH       = 16,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int DEBOUNCE_WIDTH  = 10
) (
   input  logic          clk,
   input  logic          reset,
   clock_module_if.slave bus
);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_HIGH   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [DEBOUNCE_WIDTH-1:0] DB_ZERO = {DEBOUNCE_WIDTH{1'b0}};
   localparam logic [DEBOUNCE_WIDTH-1:0] DB_ONE  = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_WIDTH-1:0]      DIV_ZERO = {DIV_WIDTH{1'b0}};
   localparam logic [DIV_WIDTH-1:0]      DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   state_t                    r_state;
   state_t                    w_next_state;
   logic [DIV_WIDTH-1:0]      r_div_cnt;
   logic [DIV_WIDTH-1:0]      w_div_cnt_d;
   logic                      r_pending;
   logic                      w_pending_d;
   logic                      r_is_manual;
   logic                      w_is_manual_d;
   logic [DEBOUNCE_WIDTH-1:0] r_db_cnt;
   logic [DEBOUNCE_WIDTH-1:0] w_db_cnt_d;
   logic                      r_db_state;
   logic                      w_db_state_d;

   logic                      w_db_differ;
   logic                      w_db_toggle;
   logic                      w_db_rise;
   logic                      w_db_fall;
   logic                      w_mode_change;
   logic [DIV_WIDTH-1:0]      w_hp_eff;
   logic                      w_div_last;
   logic                      w_phase_end;

   logic                      w_sys_clk_d;
   logic                      w_rise_d;
   logic                      w_fall_d;
   logic                      w_halted_d;
   logic                      r_sys_clk;
   logic                      r_sys_clk_n;
   logic                      r_clk_rise;
   logic                      r_clk_fall;
   logic                      r_halted;

   // Pending-mode SR latch: both or neither request asserted holds the current value.
   always_comb begin
      w_pending_d = r_pending;
      case ({bus.mode_manual, bus.mode_auto})
         2'b10:   w_pending_d = 1'b1;
         2'b01:   w_pending_d = 1'b0;
         default: w_pending_d = r_pending;
      endcase
   end

   // The debounced level flips in the same cycle the state machine sees the step event.
   assign w_db_differ  = (bus.step_btn != r_db_state);
   assign w_db_toggle  = w_db_differ && (r_db_cnt == DB_LAST);
   assign w_db_rise    = w_db_toggle && !r_db_state;
   assign w_db_fall    = w_db_toggle && r_db_state;
   assign w_db_state_d = r_db_state ^ w_db_toggle;

   // Debounce counter runs only while the raw button disagrees with the debounced level.
   always_comb begin
      w_db_cnt_d = DB_ZERO;
      if (w_db_differ && !w_db_toggle) begin
         w_db_cnt_d = r_db_cnt + DB_ONE;
      end else begin
         w_db_cnt_d = DB_ZERO;
      end
   end

   assign w_mode_change = (r_state == ST_LOW) && (r_pending != r_is_manual);
   assign w_is_manual_d = (r_state == ST_LOW) ? r_pending : r_is_manual;
   assign w_hp_eff      = (bus.half_period == DIV_ZERO) ? DIV_ONE : bus.half_period;
   assign w_div_last    = (r_div_cnt == (w_hp_eff - DIV_ONE));
   assign w_phase_end   = r_is_manual ? ((r_state == ST_HIGH) ? w_db_fall : w_db_rise)
                                      : w_div_last;

   // Divider counter: frozen when halted, parked at zero in manual mode or on a mode switch.
   always_comb begin
      w_div_cnt_d = r_div_cnt;
      if (r_state == ST_HALTED) begin
         w_div_cnt_d = r_div_cnt;
      end else if (r_is_manual || w_mode_change || w_div_last) begin
         w_div_cnt_d = DIV_ZERO;
      end else begin
         w_div_cnt_d = r_div_cnt + DIV_ONE;
      end
   end

   // Next-state logic; halt beats a rising edge in LOW but lets a HIGH phase finish.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_LOW: begin
            if (bus.halt) begin
               w_next_state = ST_HALTED;
            end else if (w_phase_end) begin
               w_next_state = ST_HIGH;
            end else begin
               w_next_state = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (w_phase_end) begin
               w_next_state = bus.halt ? ST_HALTED : ST_LOW;
            end else begin
               w_next_state = ST_HIGH;
            end
         end
         ST_HALTED: w_next_state = ST_HALTED;
         default:   w_next_state = ST_LOW;
      endcase
   end

   // Output decode from the transition, so registered outputs line up with the new state.
   always_comb begin
      w_sys_clk_d = (w_next_state == ST_HIGH);
      w_rise_d    = (r_state == ST_LOW) && (w_next_state == ST_HIGH);
      w_fall_d    = (r_state == ST_HIGH) && (w_next_state != ST_HIGH);
      w_halted_d  = (w_next_state == ST_HALTED);
   end

   // State, mode, divider and debouncer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_LOW;
         r_div_cnt   <= DIV_ZERO;
         r_pending   <= 1'b0;
         r_is_manual <= 1'b0;
         r_db_cnt    <= DB_ZERO;
         r_db_state  <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_div_cnt   <= w_div_cnt_d;
         r_pending   <= w_pending_d;
         r_is_manual <= w_is_manual_d;
         r_db_cnt    <= w_db_cnt_d;
         r_db_state  <= w_db_state_d;
      end
   end

   // Registered clock outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sys_clk   <= 1'b0;
         r_sys_clk_n <= 1'b1;
         r_clk_rise  <= 1'b0;
         r_clk_fall  <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_sys_clk   <= w_sys_clk_d;
         r_sys_clk_n <= !w_sys_clk_d;
         r_clk_rise  <= w_rise_d;
         r_clk_fall  <= w_fall_d;
         r_halted    <= w_halted_d;
      end
   end

   assign bus.sys_clk   = r_sys_clk;
   assign bus.sys_clk_n = r_sys_clk_n;
   assign bus.clk_rise  = r_clk_rise;
   assign bus.clk_fall  = r_clk_fall;
   assign bus.is_manual = r_is_manual;
   assign bus.halted    = r_halted;

`ifdef CLOCK_MODULE_CYCLE_COUNT_EN
   logic [15:0] r_cycle_count;

   // Counts rising edges, updating together with clk_rise; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_count <= 16'd0;
      end else if (w_rise_d) begin
         r_cycle_count <= r_cycle_count + 16'd1;
      end else begin
         r_cycle_count <= r_cycle_count;
      end
   end

   assign bus.cycle_count = r_cycle_count;
`else
   assign bus.cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_clock_module.sv
// Directed self-checking bench for clock_module (DEBOUNCE_CYCLES=4), inputs driven 1 time unit after each edge.
module tb_clock_module;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   clock_module_if #(.DIV_WIDTH(16)) bus ();

   clock_module #(
      .DIV_WIDTH      (16),
      .DEBOUNCE_CYCLES(4),
      .DEBOUNCE_WIDTH (10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset           = 1'b1;
      bus.half_period = 16'd3;
      bus.mode_manual = 1'b0;
      bus.mode_auto   = 1'b0;
      bus.step_btn    = 1'b0;
      bus.halt        = 1'b0;
      tick(3);
      chk("rst_sys_clk",   32'(bus.sys_clk),     32'd0);
      chk("rst_sys_clk_n", 32'(bus.sys_clk_n),   32'd1);
      chk("rst_rise",      32'(bus.clk_rise),    32'd0);
      chk("rst_fall",      32'(bus.clk_fall),    32'd0);
      chk("rst_manual",    32'(bus.is_manual),   32'd0);
      chk("rst_halted",    32'(bus.halted),      32'd0);
      chk("rst_count",     32'(bus.cycle_count), 32'd0);
      reset = 1'b0;

      // half_period=3: first rise 3 cycles after release, 3 high / 3 low
      for (int i = 1; i <= 12; i++) begin
         tick(1);
         chk("hp3_sys",  32'(bus.sys_clk),  32'(((i / 3) % 2) == 1));
         chk("hp3_rise", 32'(bus.clk_rise), 32'((i % 6) == 3));
         chk("hp3_fall", 32'(bus.clk_fall), 32'((i % 6) == 0));
      end
      chk("hp3_sys_n", 32'(bus.sys_clk_n), 32'd1);

      // half_period=0 behaves as 1: toggle every cycle
      bus.half_period = 16'd0;
      for (int j = 1; j <= 6; j++) begin
         tick(1);
         chk("hp0_sys",  32'(bus.sys_clk),  32'((j % 2) == 1));
         chk("hp0_rise", 32'(bus.clk_rise), 32'((j % 2) == 1));
         chk("hp0_fall", 32'(bus.clk_fall), 32'((j % 2) == 0));
      end

      // manual request during HIGH applies only after the falling edge
      bus.half_period = 16'd5;
      tick(4);
      chk("hp5_low", 32'(bus.sys_clk), 32'd0);
      tick(1);
      chk("hp5_rise", 32'(bus.clk_rise), 32'd1);
      bus.mode_manual = 1'b1;
      tick(1);
      bus.mode_manual = 1'b0;
      chk("mode_wait", 32'(bus.is_manual), 32'd0);
      for (int k = 7; k <= 11; k++) begin
         tick(1);
         chk("mode_manual", 32'(bus.is_manual), 32'(k == 11));
         chk("mode_sys",    32'(bus.sys_clk),   32'(k <= 9));
         chk("mode_fall",   32'(bus.clk_fall),  32'(k == 10));
      end

      // 2-cycle glitch on the step button is filtered
      bus.step_btn = 1'b1;
      for (int g = 1; g <= 8; g++) begin
         tick(1);
         if (g == 2) bus.step_btn = 1'b0;
         chk("glitch_rise", 32'(bus.clk_rise), 32'd0);
         chk("glitch_sys",  32'(bus.sys_clk),  32'd0);
      end

      // 6-cycle press: rise 4 cycles after press, fall 4 cycles after release
      bus.step_btn = 1'b1;
      for (int m = 1; m <= 6; m++) begin
         tick(1);
         chk("press_sys",  32'(bus.sys_clk),  32'(m >= 4));
         chk("press_rise", 32'(bus.clk_rise), 32'(m == 4));
      end
      bus.step_btn = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         tick(1);
         chk("release_sys",  32'(bus.sys_clk),  32'(n <= 3));
         chk("release_fall", 32'(bus.clk_fall), 32'(n == 4));
      end

      // both mode requests at once hold the current mode
      bus.mode_manual = 1'b1;
      bus.mode_auto   = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         tick(1);
         chk("both_hold", 32'(bus.is_manual), 32'd1);
      end
      bus.mode_manual = 1'b0;

      // back to auto with half_period=4
      bus.half_period = 16'd4;
      tick(1);
      bus.mode_auto = 1'b0;
      chk("auto_lag", 32'(bus.is_manual), 32'd1);
      tick(1);
      chk("auto_back", 32'(bus.is_manual), 32'd0);
      for (int h = 1; h <= 4; h++) begin
         tick(1);
         chk("hp4_rise", 32'(bus.clk_rise), 32'(h == 4));
      end

      // halt mid-HIGH: phase completes, then HALTED with clk_fall
      tick(1);
      bus.halt = 1'b1;
      chk("halt_mid_sys", 32'(bus.sys_clk), 32'd1);
      for (int h = 6; h <= 8; h++) begin
         tick(1);
         chk("halt_sys",    32'(bus.sys_clk),  32'(h <= 7));
         chk("halt_fall",   32'(bus.clk_fall), 32'(h == 8));
         chk("halt_halted", 32'(bus.halted),   32'(h == 8));
      end
      bus.halt = 1'b0;
      for (int s = 1; s <= 12; s++) begin
         tick(1);
         chk("sticky_rise",   32'(bus.clk_rise), 32'd0);
         chk("sticky_halted", 32'(bus.halted),   32'd1);
      end
      reset = 1'b1;
      tick(1);
      chk("unhalt_halted", 32'(bus.halted),    32'd0);
      chk("unhalt_sys",    32'(bus.sys_clk),   32'd0);
      chk("unhalt_sys_n",  32'(bus.sys_clk_n), 32'd1);
      chk("unhalt_manual", 32'(bus.is_manual), 32'd0);

      // halt in LOW wins over an expiring divider
      reset = 1'b0;
      tick(3);
      bus.halt = 1'b1;
      tick(1);
      chk("lowhalt_rise",   32'(bus.clk_rise), 32'd0);
      chk("lowhalt_sys",    32'(bus.sys_clk),  32'd0);
      chk("lowhalt_halted", 32'(bus.halted),   32'd1);
      bus.halt = 1'b0;

      // rising-edge counter
      reset           = 1'b1;
      bus.half_period = 16'd1;
      tick(1);
      reset = 1'b0;
`ifdef CLOCK_MODULE_CYCLE_COUNT_EN
      tick(131073);
      chk("count_rise", 32'(bus.clk_rise),    32'd1);
      chk("count_wrap", 32'(bus.cycle_count), 32'd1);
`else
      tick(9);
      chk("count_rise", 32'(bus.clk_rise),    32'd1);
      chk("count_zero", 32'(bus.cycle_count), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/clock_module.md
Name: clock_module

Overview:
- Generates the SAP-U system clock from the board clock.
- Two modes: free-running astable (programmable divider) and manual single-step (debounced push-button).
- Auto/manual selection comes from a pair of momentary set/reset inputs, held with SR-latch semantics.
- Halt input stops the system clock cleanly on a low phase; the halt sticks until reset.

Parameters:
- DIV_WIDTH, 16, width of half-period divider input.
- DEBOUNCE_CYCLES, 1000, consecutive stable board-clock cycles required before the step button's debounced state changes.
- DEBOUNCE_WIDTH, 10, counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  board clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- half_period  in  DIV_WIDTH  auto-mode cycles per clock phase; 0 treated as 1.
- mode_manual  in  1  momentary "set" of manual mode.
- mode_auto  in  1  momentary "reset" back to auto mode.
- step_btn  in  1  raw step push-button, bouncy, already synchronised.
- halt  in  1  HLT control signal from control logic.
- sys_clk  out  1  registered system clock level.
- sys_clk_n  out  1  registered complement of sys_clk.
- clk_rise  out  1  one-cycle pulse, first cycle of sys_clk high.
- clk_fall  out  1  one-cycle pulse, first cycle of sys_clk low after high.
- is_manual  out  1  current applied mode.
- halted  out  1  high in HALTED state.
- cycle_count  out  16  rising-edge count (see Optional Feature).

Behaviour:
- Reset values:
  - State LOW, divider counter 0, mode auto.
  - Pending mode auto, debounce counter 0, debounced button 0.
  - sys_clk=0, sys_clk_n=1, clk_rise=0, clk_fall=0, is_manual=0, halted=0, cycle_count=0.
  - Reset mid-phase or while HALTED takes effect on the next edge, unconditionally.
- Pending-mode latch:
  - mode_manual=1, mode_auto=0: pending=manual.
  - mode_manual=0, mode_auto=1: pending=auto.
  - 0/0: hold.
  - 1/1: hold (defined; no invalid state).
  - Pending is copied to is_manual only while state is LOW. On a mode change, the divider counter clears to 0.
- Debouncer:
  - Debounce counter increments while step_btn != debounced, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with inputs still differing, debounced toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- FSM states: LOW, HIGH, HALTED. sys_clk=1 only in HIGH.
- Auto mode:
  - Counter increments each cycle in LOW/HIGH.
  - When counter == max(half_period,1)-1, counter clears and the state toggles.
  - Each phase is exactly max(half_period,1) cycles. half_period is sampled every cycle; a change affects the current phase's compare.
- Manual mode:
  - LOW->HIGH on the debounced 0->1 transition.
  - HIGH->LOW on the debounced 1->0 transition.
  - Divider counter held at 0.
- Halt:
  - In LOW with halt=1: go to HALTED next cycle; no rising edge is emitted that cycle even if the counter expires. Halt has priority.
  - In HIGH with halt=1: the phase completes normally, then goes to HALTED instead of LOW. clk_fall pulses on that transition.
  - HALTED is exited only by reset; halt deasserting is ignored.
  - sys_clk=0 in HALTED.
- Output timing:
  - All outputs are registered.
  - clk_rise is high in the same cycle sys_clk first reads 1.
  - clk_fall is high in the same cycle sys_clk first reads 0 after HIGH.
  - clk_rise and clk_fall are never both high.

Optional Feature:
- Macro: CLOCK_MODULE_CYCLE_COUNT_EN.
- Defined: cycle_count increments by 1 on every clk_rise and wraps 16'hFFFF -> 0. It holds in HALTED and clears on reset.
- Not defined: cycle_count is driven constant 0, and no counter logic is synthesised.
- The port exists in both builds.

Test Plan:
- DEBOUNCE_CYCLES=4 in all scenarios.
- Reset then half_period=3, auto -> sys_clk toggles every 3 cycles; clk_rise pulses every 6 cycles; first rise 3 cycles after reset release.
- half_period=0 -> sys_clk toggles every cycle; clk_rise every 2 cycles.
- mode_manual pulsed while sys_clk=1 (half_period=5) -> is_manual rises only on the cycle after the falling edge.
- In manual mode:
  - step_btn glitch high for 2 cycles -> no clk_rise.
  - step_btn held 6 cycles -> sys_clk rises 4 cycles after the press and falls 4 cycles after the release.
- mode_manual=mode_auto=1 for 3 cycles -> is_manual unchanged.
- halt asserted mid-HIGH (half_period=4) -> HIGH lasts the full 4 cycles, clk_fall pulses, halted=1.
  - Further clk_rise never occurs after halt deasserts.
  - reset restores state LOW.
- With CLOCK_MODULE_CYCLE_COUNT_EN defined, half_period=1, run 65537 rises -> cycle_count=1.
- Without the macro -> cycle_count stays 0.
